edge_window_counter: RTL and testbench
======================================

// Module: edge_window_counter
// PURPOSE
//  Downstream consumer of the registered mux/AND stage output q.
//  Counts rising edges of q over fixed windows of WINDOW clock cycles.
//  Hands each window's count to the next stage through a one-entry valid/ready buffer.
//  Flags results lost to backpressure.
// PARAMETERS
//  WINDOW  16  cycles per counting window; legal range >= 2
//  CNT_W   8   count width; the count saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      sole clock; all state changes on posedge clk
//  reset      in   1      synchronous, active-high reset
//  en         in   1      run windows while high; low aborts the current window
//  din        in   1      registered q from the upstream stage
//  out_data   out  CNT_W  edge count of the last completed window
//  out_valid  out  1      out_data holds an unconsumed result
//  out_ready  in   1      downstream accepts out_data this cycle
//  busy       out  1      high while a window is in progress
//  overrun    out  1      sticky: a completed result was dropped
// BEHAVIOUR
//  Reset values (synchronous, reset has priority over everything):
//   - state=IDLE; timer=0; cnt=0; din_d=0
//   - out_data=0; out_valid=0; busy=0; overrun=0
//  Edge detect:
//   - din_d<=din every cycle, in any state.
//   - rise = din & ~din_d, combinational, same cycle as the rising din.
//  FSM states IDLE, COUNT:
//   - IDLE: en=1 -> COUNT with timer=0, cnt=0. Otherwise stay.
//   - COUNT, en=0: -> IDLE. Partial count is discarded; no output.
//   - COUNT, en=1, timer<WINDOW-1: timer++; cnt<=sat(cnt+rise).
//   - COUNT, en=1, timer==WINDOW-1: window closes.
//     Result is sat(cnt+rise), so an edge on the last cycle is counted.
//     timer<=0 and cnt<=0; stay in COUNT. The next window starts with no gap cycle.
//  busy = (state==COUNT), registered.
//  sat(): clamp to 2**CNT_W-1 and never wrap. timer width is $clog2(WINDOW).
//  Output buffer (one entry):
//   - Handshake: out_valid&out_ready -> consumed; out_valid clears next edge unless refilled.
//   - Close, buffer empty or consumed this cycle: out_data<=result; out_valid=1 next cycle.
//   - Close, out_valid=1 and out_ready=0: result dropped; out_data unchanged; overrun<=1.
//   - overrun clears only on reset.
//   - out_data is stable while out_valid=1 and out_ready=0.
//   - out_valid does not depend combinationally on out_ready.
//  Latency:
//   - out_valid rises on the edge after the close cycle.
//   - That is WINDOW cycles after the first COUNT cycle.
//  Reset mid-window or with a result pending: all state is lost; no output.
// TESTING
//  1 Reset held 2 cycles, en=1, din toggling -> all outputs 0, busy=0.
//  2 WINDOW=16, en=1, din 0,1,0,1..., out_ready=1
//    -> out_data=8, out_valid pulses 1 cycle per window.
//    Back-to-back windows give repeated 8s.
//  3 CNT_W=3, WINDOW=32, din toggling -> 16 edges -> out_data=7 (saturated).
//  4 out_ready=0 across two window closes
//    -> first count held, overrun=1.
//    Then out_ready=1 -> first count read once; out_valid=0.
//  5 out_ready=1 on a close cycle with a result pending
//    -> new count loaded, out_valid stays 1, overrun stays 0.
//  6 Abort and reset cases:
//    - en dropped at timer=5 -> busy=0 next cycle; no out_valid.
//    - reset at timer=9 -> same; next window counts from 0.

Source files
------------

// File: rtl/edge_window_counter.sv
// Counts rising edges of din over back-to-back windows of WINDOW cycles and
// hands each window's saturated count downstream through a one-entry valid/ready buffer.
module edge_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    output logic [CNT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);
    localparam int               TW      = $clog2(WINDOW);
    localparam logic [TW-1:0]    LAST    = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             din_d;
    logic             rise;

    assign rise = din & ~din_d;

    // NOTE: default assignment first so every path drives cnt_next and no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (rise && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            cnt       <= '0;
            din_d     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            din_d <= din;
            // NOTE: a refill at window close comes later in this block, so it overrides this clear.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        timer <= '0;
                        cnt   <= '0;
                    end
                end
                COUNT: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        timer <= '0;
                        cnt   <= '0;
                    end else if (timer == LAST) begin
                        timer <= '0;
                        cnt   <= '0;
                        if (!out_valid || out_ready) begin
                            out_data  <= cnt_next;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        cnt   <= cnt_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_edge_window_counter.sv
// Self-checking bench: table of 16-cycle din patterns with hand-derived counts,
// queue scoreboard on every handshake, plus sequences for backpressure, abort and reset.
module tb_edge_window_counter;
    logic       clk = 1'b0;
    logic       reset;
    logic       sat_off;
    logic       reset_s;
    logic       en;
    logic       din;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic [2:0] s_data;
    logic       s_valid;
    logic       s_busy;
    logic       s_overrun;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int sat_q[$];
    int valid_cycles = 0;
    int s_valid_cycles = 0;

    typedef struct {
        logic [15:0] pat;
        int          exp16;
    } vec_t;

    vec_t vecs[8];
    int   exp_sat[4];

    always #5 clk = ~clk;
    assign reset_s = reset | sat_off;

    edge_window_counter #(.WINDOW(16), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .din      (din),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    edge_window_counter #(.WINDOW(32), .CNT_W(3)) dut_sat (
        .clk      (clk),
        .reset    (reset_s),
        .en       (en),
        .din      (din),
        .out_data (s_data),
        .out_valid(s_valid),
        .out_ready(out_ready),
        .busy     (s_busy),
        .overrun  (s_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboards: every accepted result must match the oldest expected count.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            valid_cycles++;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_count", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_s && s_valid) begin
            s_valid_cycles++;
            if (out_ready) begin
                if (sat_q.size() == 0) begin
                    check("unexpected_sat_result", 32'(s_data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_sat_count", 32'(s_data), 32'(sat_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then one IDLE cycle with en=1; the first counting cycle follows.
    task automatic restart();
        reset = 1'b1;
        en    = 1'b0;
        din   = 1'b0;
        step();
        reset = 1'b0;
        en    = 1'b1;
        step();
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic drive_bits(input logic [15:0] pat, input int n, input int push_val);
        for (int i = 0; i < n; i++) begin
            din = pat[i];
            if (i == n - 1 && push_val >= 0) exp_q.push_back(push_val);
            step();
        end
    endtask

    initial begin
        int  vbase;
        int  sbase;
        logic seen;

        vecs[0] = '{pat: 16'h5555, exp16: 8};
        vecs[1] = '{pat: 16'h5555, exp16: 8};
        vecs[2] = '{pat: 16'h00FF, exp16: 1};
        vecs[3] = '{pat: 16'h0F0F, exp16: 2};
        vecs[4] = '{pat: 16'h1111, exp16: 4};
        vecs[5] = '{pat: 16'h7FFF, exp16: 1};
        vecs[6] = '{pat: 16'h2492, exp16: 5};
        vecs[7] = '{pat: 16'h0001, exp16: 1};
        exp_sat = '{7, 3, 5, 6};

        // Reset held two cycles with en high and din toggling.
        sat_off   = 1'b0;
        reset     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        din       = 1'b1;
        step();
        din = 1'b0;
        step();
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sat_valid", 32'(s_valid), 32'd0);

        // Back-to-back windows, out_ready held high.
        restart();
        vbase = valid_cycles;
        sbase = s_valid_cycles;
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 16; i++) begin
                din = vecs[w].pat[i];
                if (i == 15) begin
                    exp_q.push_back(vecs[w].exp16);
                    if (w % 2 == 1) sat_q.push_back(exp_sat[w / 2]);
                end
                step();
            end
            if (w == 0) check("first_valid_latency", 32'(out_valid), 32'd1);
        end
        din = 1'b0;
        step();
        check("valid_pulses", 32'(valid_cycles - vbase), 32'd8);
        check("sat_valid_pulses", 32'(s_valid_cycles - sbase), 32'd4);
        check("no_overrun_streaming", 32'(overrun), 32'd0);
        sat_off = 1'b1;

        // Backpressure across two closes: first count held, second dropped.
        restart();
        out_ready = 1'b0;
        drive_bits(16'h5555, 16, 8);
        check("bp_valid_1", 32'(out_valid), 32'd1);
        check("bp_data_1", 32'(out_data), 32'd8);
        check("bp_overrun_0", 32'(overrun), 32'd0);
        drive_bits(16'h00FF, 16, -1);
        check("bp_overrun_1", 32'(overrun), 32'd1);
        check("bp_data_held", 32'(out_data), 32'd8);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        din       = 1'b0;
        step();
        check("bp_valid_cleared", 32'(out_valid), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);

        // Consume and refill on the same close cycle.
        restart();
        out_ready = 1'b0;
        drive_bits(16'h1111, 16, 4);
        check("refill_data_1", 32'(out_data), 32'd4);
        drive_bits(16'h2492, 15, -1);
        out_ready = 1'b1;
        din       = 1'b0;
        exp_q.push_back(5);
        step();
        check("refill_valid", 32'(out_valid), 32'd1);
        check("refill_data_2", 32'(out_data), 32'd5);
        check("refill_no_overrun", 32'(overrun), 32'd0);
        step();
        check("refill_drained", 32'(out_valid), 32'd0);

        // Abort at timer=5: no result ever appears.
        restart();
        drive_bits(16'h5555, 5, -1);
        check("abort_busy_before", 32'(busy), 32'd1);
        en  = 1'b0;
        din = 1'b0;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen |= out_valid;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        // Reset at timer=9, then a fresh window counts from zero.
        restart();
        drive_bits(16'h5555, 9, -1);
        reset = 1'b1;
        step();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        en    = 1'b1;
        din   = 1'b0;
        step();
        drive_bits(16'h0F0F, 16, 2);
        check("midrst_data", 32'(out_data), 32'd2);
        check("midrst_valid_after", 32'(out_valid), 32'd1);
        din = 1'b0;
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("sat_scoreboard_drained", 32'(sat_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
